gcd: RTL and testbench

GCD -- requirements
Module: gcd

---
 rtl/gcd_pkg.sv | 14 +
 rtl/gcd_datapath.sv | 56 +++++
 rtl/gcd.sv | 96 +++++++++
 tb/tb_gcd.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types and constants for the gcd block
//   GCD_WIDTH   : default operand/result width
//   gcd_state_t : controller states IDLE, CALC, DONE
package gcd_pkg;

  localparam int GCD_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_t;

endpackage

// File: rtl/gcd_datapath.sv
// rtl/gcd_datapath.sv - x/y operand registers with compare, subtract and zero detect
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset, clears x and y
//   i_load   : capture i_a/i_b into x/y
//   i_step   : one subtract step, smaller operand taken from the larger
//   i_a/i_b  : operands, only looked at while i_load is high
//   o_x/o_y  : current operand registers
//   o_x_zero/o_y_zero/o_x_eq_y/o_x_gt_y : compare results on the current registers
module gcd_datapath #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_x,
  output logic [WIDTH-1:0] o_y,
  output logic             o_x_zero,
  output logic             o_y_zero,
  output logic             o_x_eq_y,
  output logic             o_x_gt_y
);

  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             w_x_gt_y;

  assign w_x_gt_y = (r_x > r_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_load) begin
      r_x <= i_a;
      r_y <= i_b;
    end else if (i_step) begin
      // The larger register always loses the smaller, so the difference cannot wrap.
      if (w_x_gt_y) begin
        r_x <= r_x - r_y;
      end else begin
        r_y <= r_y - r_x;
      end
    end
  end

  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_x_zero = (r_x == '0);
  assign o_y_zero = (r_y == '0);
  assign o_x_eq_y = (r_x == r_y);
  assign o_x_gt_y = w_x_gt_y;

endmodule

// File: rtl/gcd.sv
// rtl/gcd.sv - subtractive greatest-common-divisor engine with go/done handshake
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   go   : start request (level); must drop after done before the next start
//   a, b : unsigned operands, captured on the start edge only
//   done : registered result-valid flag, held while go stays high
//   ans  : registered result, held until the next completion or reset
module gcd
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] ans
);

  gcd_state_t       r_state;
  logic             r_done;
  logic [WIDTH-1:0] r_ans;

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_x_zero;
  logic             w_y_zero;
  logic             w_x_eq_y;
  logic             w_x_gt_y;
  logic             w_load;
  logic             w_finish;
  logic             w_step;

  // Any of the three terminating conditions ends the calculation; otherwise subtract.
  assign w_load   = (r_state == IDLE) && go;
  assign w_finish = w_x_zero || w_y_zero || w_x_eq_y;
  assign w_step   = (r_state == CALC) && !w_finish;

  gcd_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_a      (a),
    .i_b      (b),
    .o_x      (w_x),
    .o_y      (w_y),
    .o_x_zero (w_x_zero),
    .o_y_zero (w_y_zero),
    .o_x_eq_y (w_x_eq_y),
    .o_x_gt_y (w_x_gt_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_ans   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (go) begin
            r_state <= CALC;
          end
        end
        CALC: begin
          // x==0 yields y (covers gcd(0,0)=0); y==0 or x==y yields x.
          if (w_finish) begin
            r_ans   <= w_x_zero ? w_y : w_x;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          // Holding go keeps the result up; only a drop of go re-arms the engine.
          if (!go) begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign done = r_done;
  assign ans  = r_ans;

endmodule

// File: tb/tb_gcd.sv
// tb/tb_gcd.sv - scoreboard bench for gcd with random and directed operands
module tb_gcd;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         go;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         done;
  logic [W-1:0] ans;

  gcd #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .go   (go),
    .a    (a),
    .b    (b),
    .done (done),
    .ans  (ans)
  );

  always #5 clk = ~clk;

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int unsigned ans;
    int unsigned edge_no;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Euclid by division; subtract steps = sum of quotients, minus one because
  // the subtractive form stops at x==y instead of subtracting to zero.
  task automatic ref_model(input int unsigned aa, input int unsigned bb,
                           output int unsigned g, output int unsigned steps);
    int unsigned p, q, t, qsum;
    if (aa == 0) begin g = bb; steps = 0; end
    else if (bb == 0) begin g = aa; steps = 0; end
    else begin
      p = aa; q = bb; qsum = 0;
      while (q != 0) begin
        qsum += p / q;
        t = p % q; p = q; q = t;
      end
      g = p; steps = qsum - 1;
    end
  endtask

  // Monitor: every rising edge of done consumes one scoreboard entry.
  logic prev_done = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && !prev_done) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got done=1 with ans=%0d expected no completion", ans);
        end else begin
          e = sb.pop_front();
          check("ans", ans, e.ans);
          check("latency_edge", edge_cnt, e.edge_no);
        end
      end
      prev_done = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int unsigned aa, input int unsigned bb, input bit push,
                       output int unsigned g, output int unsigned steps);
    exp_t e;
    ref_model(aa, bb, g, steps);
    a  = W'(aa);
    b  = W'(bb);
    go = 1'b1;
    if (push) begin
      e.ans     = g;
      e.edge_no = edge_cnt + 1 + steps + 1;
      sb.push_back(e);
    end
    tick();
    // Operands are scrambled right after the start edge; the result must not care.
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic finish_op(input int unsigned exp_ans, input int budget, input int hold);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check("done_within_budget", done, 1);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("done_held", done, 1);
      check("ans_held", ans, exp_ans);
    end
    go = 1'b0;
    tick();
    check("done_cleared", done, 0);
    check("ans_after_drop", ans, exp_ans);
  endtask

  task automatic run_op(input int unsigned aa, input int unsigned bb, input int hold);
    int unsigned g, steps;
    start(aa, bb, 1'b1, g, steps);
    finish_op(g, int'(steps) + 5, hold);
  endtask

  initial begin
    int unsigned g, steps;
    int unsigned ra, rb, k;

    // Reset with go already high: reset must win.
    rst = 1'b1; go = 1'b1; a = 16'd10; b = 16'd8;
    tick();
    tick();
    check("rst_done", done, 0);
    check("rst_ans", ans, 0);

    // First edge with rst=0 and go=1 is the start edge.
    rst = 1'b0;
    start(10, 8, 1'b1, g, steps);
    finish_op(g, int'(steps) + 5, 3);

    run_op(12, 12, 1);
    run_op(0, 7, 1);
    run_op(9, 0, 1);
    run_op(0, 0, 1);
    run_op(1071, 462, 1);
    run_op(48, 18, 2);

    for (int i = 0; i < 24; i++) begin
      k  = $urandom_range(1, 12);
      ra = $urandom_range(0, 40) * k;
      rb = $urandom_range(0, 40) * k;
      if (i % 4 == 0) ra = $urandom_range(0, 255);
      run_op(ra, rb, $urandom_range(0, 3));
    end

    // Known nonzero result on ans, then abort a long computation with reset.
    run_op(48, 18, 0);
    start(65535, 1, 1'b0, g, steps);
    repeat (30) tick();
    check("calc_done_low", done, 0);
    check("calc_ans_holds_prev", ans, 6);
    rst = 1'b1; go = 1'b0;
    tick();
    check("abort_done", done, 0);
    check("abort_ans", ans, 0);
    rst = 1'b0;
    tick();
    check("idle_after_abort_done", done, 0);
    run_op(10, 8, 1);

    // Worst-case latency.
    run_op(65535, 1, 1);

    repeat (4) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
